// File: rtl/b4_serial_loader.sv
// Serial frame receiver feeding the 4-bit enabled register stage.
// Assembles start/data/parity/stop frames into a word, then emits a load or error pulse.
module b4_serial_loader #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] D_out,
  output logic             en_out,
  output logic             err_out,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_err_q, par_err_d;
  logic [WIDTH-1:0]   d_out_q, d_out_d;
  logic               en_q, en_d;
  logic               err_q, err_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    par_err_d   = par_err_q;
    d_out_d     = d_out_q;
    frame_cnt_d = frame_cnt_q;
    en_d        = 1'b0;
    err_d       = 1'b0;
    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d   = DATA;
            cnt_d     = '0;
            par_err_d = 1'b0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = sin;
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY_EN ? PAR : STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PAR: begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          par_err_d = (sin != ^shift_q);
          state_d   = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (sin && !par_err_q) begin
            d_out_d     = shift_q;
            en_d        = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      par_err_q   <= 1'b0;
      d_out_q     <= '0;
      en_q        <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      par_err_q   <= par_err_d;
      d_out_q     <= d_out_d;
      en_q        <= en_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign D_out     = d_out_q;
  assign en_out    = en_q;
  assign err_out   = err_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_b4_serial_loader.sv
// Self-checking bench for b4_serial_loader: directed frames from the test list plus
// randomized frames, compared against a frame-level model of good/error outcomes.
module tb_b4_serial_loader;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       bit_valid;
  logic [3:0] D_out;
  logic       en_out;
  logic       err_out;
  logic       busy;
  logic [7:0] frame_cnt;

  int checks;
  int failures;

  // Frame-level reference state
  logic [3:0] exp_dout;
  int         exp_cnt;
  int         exp_en_pulses;
  int         exp_err_pulses;

  // Pulse monitor
  int en_pulses;
  int err_pulses;
  int both_high;

  b4_serial_loader #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .bit_valid (bit_valid),
    .D_out     (D_out),
    .en_out    (en_out),
    .err_out   (err_out),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (en_out) en_pulses++;
      if (err_out) err_pulses++;
      if (en_out && err_out) both_high++;
    end
  end

  // Drives one frame; gap idle cycles (bit_valid=0, random sin) precede every bit.
  // Returns 1 time unit after the edge that samples the stop bit.
  task automatic send_frame(input logic [3:0] word, input bit bad_par, input bit stop_val,
                            input int gap);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 4; i++) bits.push_back(word[i]);
    bits.push_back((^word) ^ bad_par);
    bits.push_back(stop_val);
    foreach (bits[i]) begin
      repeat (gap) begin
        bit_valid = 1'b0;
        sin       = 1'($urandom);
        @(posedge clk); #1;
      end
      sin       = bits[i];
      bit_valid = 1'b1;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    sin       = 1'b1;
  endtask

  // Updates the reference for one frame and returns whether it is a good frame.
  function automatic bit model_frame(input logic [3:0] word, input bit bad_par,
                                     input bit stop_val);
    bit good;
    good = stop_val && !bad_par;
    if (good) begin
      exp_dout = word;
      exp_cnt  = (exp_cnt + 1) % 256;
      exp_en_pulses++;
    end else begin
      exp_err_pulses++;
    end
    return good;
  endfunction

  task automatic test_reset;
    rst       = 1'b1;
    sin       = 1'b1;
    bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({D_out, en_out, err_out, busy, frame_cnt} !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got D_out=%0d en=%0b err=%0b busy=%0b cnt=%0d, want all 0",
               D_out, en_out, err_out, busy, frame_cnt);
    end
    sin       = 1'b1;
    bit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || en_out !== 1'b0 || err_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_line: cycle %0d busy=%0b en=%0b err=%0b, want 0", i, busy,
                 en_out, err_out);
      end
    end
    bit_valid = 1'b0;
  endtask

  // One frame plus the checks on its outcome and the single-cycle pulse width.
  task automatic test_one_frame(input string name, input logic [3:0] word, input bit bad_par,
                                input bit stop_val, input int gap);
    bit good;
    good = model_frame(word, bad_par, stop_val);
    send_frame(word, bad_par, stop_val, gap);
    checks++;
    if (en_out !== good || err_out !== !good) begin
      failures++;
      $display("[TB] FAIL %s_pulse: en=%0b err=%0b, want en=%0b err=%0b", name, en_out, err_out,
               good, !good);
    end
    checks++;
    if (D_out !== exp_dout || frame_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL %s_data: D_out=%0d cnt=%0d, want D_out=%0d cnt=%0d", name, D_out,
               frame_cnt, exp_dout, exp_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (en_out !== 1'b0 || err_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_width: en=%0b err=%0b busy=%0b one cycle later, want 0", name,
               en_out, err_out, busy);
    end
  endtask

  task automatic test_good_frames;
    test_one_frame("frame9", 4'd9, 1'b0, 1'b1, 0);
    test_one_frame("frame15_slow", 4'd15, 1'b0, 1'b1, 1);
  endtask

  task automatic test_errors;
    test_one_frame("bad_parity", 4'd9, 1'b1, 1'b1, 0);
    test_one_frame("bad_stop", 4'd9, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_frame;
    int en_before;
    int err_before;
    en_before  = en_pulses;
    err_before = err_pulses;
    bit_valid  = 1'b1;
    sin = 1'b0; @(posedge clk); #1;
    sin = 1'b0; @(posedge clk); #1;
    sin = 1'b1; @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_frame_busy: busy=%0b, want 1", busy);
    end
    bit_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    exp_dout = 4'd0;
    exp_cnt  = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || D_out !== 4'd0 || frame_cnt !== 8'd0 || en_pulses != en_before ||
        err_pulses != err_before) begin
      failures++;
      $display("[TB] FAIL mid_frame_reset: busy=%0b D_out=%0d cnt=%0d en+%0d err+%0d, want 0s",
               busy, D_out, frame_cnt, en_pulses - en_before, err_pulses - err_before);
    end
    test_one_frame("after_reset6", 4'd6, 1'b0, 1'b1, 0);
  endtask

  task automatic test_wrap;
    logic [3:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 4'($urandom);
      void'(model_frame(w, 1'b0, 1'b1));
      send_frame(w, 1'b0, 1'b1, 0);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_cnt !== 8'(exp_cnt) || exp_cnt != 1 || D_out !== exp_dout) begin
      failures++;
      $display("[TB] FAIL wrap: cnt=%0d D_out=%0d, want cnt=%0d D_out=%0d", frame_cnt, D_out,
               exp_cnt, exp_dout);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] w1;
    logic [3:0] w2;
    int         en_before;
    w1 = 4'($urandom);
    w2 = ~w1;
    en_before = en_pulses;
    void'(model_frame(w1, 1'b0, 1'b1));
    send_frame(w1, 1'b0, 1'b1, 0);
    checks++;
    if (en_out !== 1'b1 || D_out !== w1) begin
      failures++;
      $display("[TB] FAIL b2b_first: en=%0b D_out=%0d, want en=1 D_out=%0d", en_out, D_out, w1);
    end
    void'(model_frame(w2, 1'b0, 1'b1));
    send_frame(w2, 1'b0, 1'b1, 0);
    checks++;
    if (en_out !== 1'b1 || D_out !== w2 || frame_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL b2b_second: en=%0b D_out=%0d cnt=%0d, want en=1 D_out=%0d cnt=%0d",
               en_out, D_out, frame_cnt, w2, exp_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (en_pulses - en_before != 2) begin
      failures++;
      $display("[TB] FAIL b2b_pulses: got %0d en pulses, want 2", en_pulses - en_before);
    end
  endtask

  task automatic test_random;
    logic [3:0] w;
    bit         bp;
    bit         sv;
    for (int i = 0; i < 40; i++) begin
      w  = 4'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 3) != 0);
      test_one_frame("random", w, bp, sv, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_pulse_totals;
    checks++;
    if (en_pulses != exp_en_pulses || err_pulses != exp_err_pulses || both_high != 0) begin
      failures++;
      $display("[TB] FAIL pulse_totals: en=%0d err=%0d both=%0d, want en=%0d err=%0d both=0",
               en_pulses, err_pulses, both_high, exp_en_pulses, exp_err_pulses);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    exp_dout       = 4'd0;
    exp_cnt        = 0;
    exp_en_pulses  = 0;
    exp_err_pulses = 0;
    en_pulses      = 0;
    err_pulses     = 0;
    both_high      = 0;
    rst            = 1'b1;
    sin            = 1'b1;
    bit_valid      = 1'b0;
    test_reset;
    test_good_frames;
    test_errors;
    test_reset_mid_frame;
    test_wrap;
    test_back_to_back;
    test_random;
    test_pulse_totals;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
